// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with RV32I load/store unit: lane-masked stores,
// sign/zero-extended loads, fault detection, and a zero-fill sweep after reset.
`timescale 1ns/1ps
module dmem_lsu #(
    parameter int ADDR_WIDTH     = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault,
    output logic                  init_done
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int WORDS = 1 << IDX_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   cnt_reg, cnt_next;

    logic [31:0]        mem [0:WORDS-1];
    logic [31:0]        rd_word_reg;

    logic [IDX_W-1:0]   req_idx;
    logic [1:0]         lane;
    logic               accept;
    logic               illegal;
    logic               misaligned;
    logic               fault;

    logic [3:0]         st_lane_en;
    logic [31:0]        st_data;

    logic [3:0]         wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [31:0]        wr_data;

    logic               rsp_valid_reg;
    logic               rsp_fault_reg;
    logic               rsp_load_reg;
    logic [2:0]         rsp_f3_reg;
    logic [1:0]         rsp_lane_reg;
    logic [31:0]        shifted;

    assign req_idx = req_addr[ADDR_WIDTH-1:2];
    assign lane    = req_addr[1:0];

    // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
    always_comb begin
        illegal    = 1'b1;
        misaligned = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: illegal = 1'b0;
                default:                illegal = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
                default:                                illegal = 1'b1;
            endcase
        end
        case (req_funct3[1:0])
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b0;
        endcase
        fault = illegal | misaligned;
    end

    // Store data is replicated across lanes so each lane picks its own byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE_ID = 2'(gi);
        assign st_lane_en[gi] = (req_funct3[1:0] == 2'b10)
                              | ((req_funct3[1:0] == 2'b01) && (lane[1] == LANE_ID[1]))
                              | ((req_funct3[1:0] == 2'b00) && (lane == LANE_ID));
        assign st_data[gi*8 +: 8] = (req_funct3[1:0] == 2'b00) ? req_wdata[7:0] :
                                    (req_funct3[1:0] == 2'b01) ? req_wdata[(gi%2)*8 +: 8] :
                                                                 req_wdata[gi*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CLEAR_ON_RESET ? INIT : RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        accept     = 1'b0;
        wr_en      = 4'b0000;
        wr_idx     = req_idx;
        wr_data    = st_data;
        case (state_reg)
            INIT: begin
                wr_en    = 4'b1111;
                wr_idx   = cnt_reg;
                wr_data  = 32'h0;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == IDX_W'(WORDS - 1)) begin
                    state_next = RUN;
                end
            end
            default: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid && req_we && !fault) begin
                    wr_en = st_lane_en;
                end
            end
        endcase
    end

    // Array port: byte-masked write plus registered read; a store in cycle n
    // is visible to a load accepted in cycle n+1.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
        if (accept && !req_we) begin
            rd_word_reg <= mem[req_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_fault_reg <= 1'b0;
            rsp_load_reg  <= 1'b0;
            rsp_f3_reg    <= 3'b000;
            rsp_lane_reg  <= 2'b00;
        end else begin
            rsp_valid_reg <= accept;
            rsp_fault_reg <= accept && fault;
            rsp_load_reg  <= accept && !req_we && !fault;
            if (accept) begin
                rsp_f3_reg   <= req_funct3;
                rsp_lane_reg <= lane;
            end
        end
    end

    assign shifted = rd_word_reg >> {rsp_lane_reg, 3'b000};

    always_comb begin
        rsp_rdata = 32'h0;
        if (rsp_load_reg) begin
            case (rsp_f3_reg)
                3'b000:  rsp_rdata = {{24{shifted[7]}}, shifted[7:0]};
                3'b001:  rsp_rdata = {{16{shifted[15]}}, shifted[15:0]};
                3'b010:  rsp_rdata = shifted;
                3'b100:  rsp_rdata = {24'h0, shifted[7:0]};
                3'b101:  rsp_rdata = {16'h0, shifted[15:0]};
                default: rsp_rdata = 32'h0;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_fault = rsp_fault_reg;
    assign init_done = (state_reg == RUN);

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: reset sweep timing, load/store widths, faults,
// back-to-back traffic and reset behaviour, with hand-computed expectations.
`timescale 1ns/1ps
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    dmem_lsu #(.ADDR_WIDTH(8), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Counts cycles until req_ready rises; any request held during the sweep
    // must be ignored, then it is dropped before the first RUN edge.
    task automatic wait_sweep(input string tag);
        int n = 0;
        int seen = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
            if (rsp_valid) seen++;
        end
        req_valid = 1'b0;
        $display("sweep %s: ready after %0d cycles", tag, n);
        check({tag, "/cycles"}, 32'(n), 32'd64);
        check({tag, "/init_done"}, 32'(init_done), 32'd1);
        check({tag, "/no_rsp"}, 32'(seen), 32'd0);
    endtask

    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_f);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        $display("xact %-10s we=%0d f3=%03b addr=%02h wdata=%08h -> valid=%0d rdata=%08h fault=%0d",
                 tag, we, f3, addr, wd, rsp_valid, rsp_rdata, rsp_fault);
        check({tag, "/valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "/rdata"}, rsp_rdata, exp_d);
        check({tag, "/fault"}, 32'(rsp_fault), 32'(exp_f));
        @(negedge clk);
        check({tag, "/pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 8'h00;
        req_wdata  = 32'h0;
        #1;
        check("rst/valid", 32'(rsp_valid), 32'd0);
        check("rst/rdata", rsp_rdata, 32'h0);
        check("rst/init_done", 32'(init_done), 32'd0);
        check("rst/ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-sweep reset must restart the sweep from word 0.
        repeat (20) @(negedge clk);
        check("mid/ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid/init_done", 32'(init_done), 32'd0);
        check("mid/valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 8'hFC;
        req_wdata  = 32'hFFFF_FFFF;
        req_valid  = 1'b1;
        wait_sweep("sweep1");

        xact("lw_fc", 1'b0, 3'b010, 8'hFC, 32'h0, 32'h0000_0000, 1'b0);

        xact("sw_10", 1'b1, 3'b010, 8'h10, 32'h8000_80F1, 32'h0, 1'b0);
        xact("lb_10", 1'b0, 3'b000, 8'h10, 32'h0, 32'hFFFF_FFF1, 1'b0);
        xact("lbu_10", 1'b0, 3'b100, 8'h10, 32'h0, 32'h0000_00F1, 1'b0);
        xact("lb_11", 1'b0, 3'b000, 8'h11, 32'h0, 32'hFFFF_FF80, 1'b0);
        xact("lbu_13", 1'b0, 3'b100, 8'h13, 32'h0, 32'h0000_0080, 1'b0);
        xact("lh_12", 1'b0, 3'b001, 8'h12, 32'h0, 32'hFFFF_8000, 1'b0);
        xact("lhu_12", 1'b0, 3'b101, 8'h12, 32'h0, 32'h0000_8000, 1'b0);
        xact("lhu_10", 1'b0, 3'b101, 8'h10, 32'h0, 32'h0000_80F1, 1'b0);
        xact("lw_10", 1'b0, 3'b010, 8'h10, 32'h0, 32'h8000_80F1, 1'b0);

        xact("sw_20", 1'b1, 3'b010, 8'h20, 32'h1122_3344, 32'h0, 1'b0);
        xact("sb_21", 1'b1, 3'b000, 8'h21, 32'hFFFF_FFAB, 32'h0, 1'b0);
        xact("lw_20a", 1'b0, 3'b010, 8'h20, 32'h0, 32'h1122_AB44, 1'b0);
        xact("sh_22", 1'b1, 3'b001, 8'h22, 32'h1234_BEEF, 32'h0, 1'b0);
        xact("lw_20b", 1'b0, 3'b010, 8'h20, 32'h0, 32'hBEEF_AB44, 1'b0);

        xact("sw_04", 1'b1, 3'b010, 8'h04, 32'hCAFE_F00D, 32'h0, 1'b0);
        xact("lw_05", 1'b0, 3'b010, 8'h05, 32'h0, 32'h0, 1'b1);
        xact("sh_07", 1'b1, 3'b001, 8'h07, 32'h0, 32'h0, 1'b1);
        xact("sw_06", 1'b1, 3'b010, 8'h06, 32'h0, 32'h0, 1'b1);
        xact("st_f011", 1'b1, 3'b011, 8'h04, 32'h0, 32'h0, 1'b1);
        xact("st_f100", 1'b1, 3'b100, 8'h04, 32'h0, 32'h0, 1'b1);
        xact("ld_f011", 1'b0, 3'b011, 8'h04, 32'h0, 32'h0, 1'b1);
        xact("ld_f110", 1'b0, 3'b110, 8'h04, 32'h0, 32'h0, 1'b1);
        xact("lh_05", 1'b0, 3'b001, 8'h05, 32'h0, 32'h0, 1'b1);
        xact("lw_04", 1'b0, 3'b010, 8'h04, 32'h0, 32'hCAFE_F00D, 1'b0);
        xact("lh_06", 1'b0, 3'b001, 8'h06, 32'h0, 32'hFFFF_CAFE, 1'b0);

        // Back-to-back store then load of the same word.
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 8'h30;
        req_wdata  = 32'hDEAD_BEEF;
        req_valid  = 1'b1;
        @(negedge clk);
        $display("b2b store 30: valid=%0d rdata=%08h", rsp_valid, rsp_rdata);
        check("b2b/sw_valid", 32'(rsp_valid), 32'd1);
        check("b2b/sw_rdata", rsp_rdata, 32'h0);
        req_we     = 1'b0;
        req_wdata  = 32'h0;
        @(negedge clk);
        req_valid  = 1'b0;
        $display("b2b load 30: valid=%0d rdata=%08h", rsp_valid, rsp_rdata);
        check("b2b/lw_valid", 32'(rsp_valid), 32'd1);
        check("b2b/lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("b2b/idle", 32'(rsp_valid), 32'd0);

        // Reset while a load response is due: no pulse, then a fresh sweep.
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 8'h30;
        req_valid  = 1'b1;
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        $display("reset with response due: valid=%0d", rsp_valid);
        check("rstdue/valid", 32'(rsp_valid), 32'd0);
        check("rstdue/init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sweep("sweep2");
        xact("lw_30clr", 1'b0, 3'b010, 8'h30, 32'h0, 32'h0, 1'b0);
        xact("lw_10clr", 1'b0, 3'b010, 8'h10, 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
